// File: rtl/arb_pkg.sv
// Shared types and helpers for the parametrised mutex arbiter.
// Imported by the picker and the arbiter top.
package arb_pkg;

  localparam int unsigned ARB_PRIORITY = 0;
  localparam int unsigned ARB_RR       = 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_t;

  // $clog2 that never returns zero, so a value of 0 or 1 still gets a 1-bit field
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: highest set index, or first set bit at/after start_i with wrap.
// Wrap is done with explicit compare-and-subtract, so N_REQ need not be a power of two.
module arb_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             mode_i,        // 1 = round robin, 0 = fixed priority
  output logic [N_REQ-1:0] winner_o,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             any_o
);

  always_comb begin
    logic        found;
    int unsigned idx;
    found        = 1'b0;
    idx          = 0;
    winner_idx_o = '0;
    any_o        = |req_i;
    if (mode_i) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = 32'(start_i) + k;
        if (idx >= N_REQ) begin
          idx = idx - N_REQ;
        end
        if (!found && req_i[IDX_W'(idx)]) begin
          found        = 1'b1;
          winner_idx_o = IDX_W'(idx);
        end
      end
    end else begin
      // Later (higher) indices overwrite earlier ones
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (req_i[IDX_W'(k)]) begin
          winner_idx_o = IDX_W'(k);
        end
      end
    end
    winner_o = any_o ? (N_REQ'(1) << winner_idx_o) : '0;
  end

endmodule

// File: rtl/mutex_arbiter_n.sv
// N-way mutex arbiter with registered one-hot grant, grant hold while requested,
// and a hold-timeout that forces release when other requesters are waiting.
module mutex_arbiter_n
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MODE     = 1,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDX_W   = $clog2(N_REQ),
  localparam int unsigned CNT_W   = clog2_min1(MAX_HOLD + 1)
) (
  input  logic             bus_clk_i,
  input  logic             bus_rst_ni,
  input  logic             arb_en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic [CNT_W-1:0] hold_cnt_o,
  output logic             timeout_pulse_o
);

  // With MAX_HOLD == 0 the counter simply saturates at all-ones
  localparam logic [CNT_W-1:0] CntMax = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tpulse_q, tpulse_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] next_ptr;
  logic             issue;
  logic             owner_req;
  logic             others_req;
  logic             at_limit;

  arb_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i        (req_i),
    .start_i      (ptr_q),
    .mode_i       (MODE != ARB_PRIORITY),
    .winner_o     (pick_onehot),
    .winner_idx_o (pick_idx),
    .any_o        (pick_any)
  );

  assign issue      = arb_en_i && pick_any;
  assign owner_req  = req_i[idx_q];
  assign others_req = |(req_i & ~grant_q);
  assign at_limit   = (MAX_HOLD != 0) && (cnt_q == CntMax);
  assign next_ptr   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge bus_clk_i or negedge bus_rst_ni) begin
    if (!bus_rst_ni) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tpulse_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tpulse_q <= tpulse_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (issue) state_d = ARB_OWNED;
      ARB_OWNED: if (!owner_req || (at_limit && others_req)) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tpulse_d = 1'b0;
    ptr_d    = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (issue) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          cnt_d   = CNT_W'(1);
          ptr_d   = next_ptr;
        end else begin
          grant_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ARB_OWNED: begin
        // An owner drop wins over a coincident timeout: plain release, no pulse
        if (!owner_req || (at_limit && others_req)) begin
          grant_d  = '0;
          idx_d    = '0;
          cnt_d    = '0;
          tpulse_d = owner_req;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    valid_d = |grant_d;
  end

  assign grant_o         = grant_q;
  assign grant_valid_o   = valid_q;
  assign grant_idx_o     = idx_q;
  assign hold_cnt_o      = cnt_q;
  assign timeout_pulse_o = tpulse_q;

endmodule

// File: tb/tb_mutex_arbiter_n.sv
// Bench for mutex_arbiter_n: a fixed-priority and a round-robin instance (N_REQ=4, MAX_HOLD=4)
// share stimulus; both are checked against a rule-level reference model plus directed values.
module tb_mutex_arbiter_n;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int CW = 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          arb_en = 1'b0;
  logic [N-1:0]  req    = '0;

  logic [N-1:0]  grant_w [2];
  logic          valid_w [2];
  logic [1:0]    idx_w   [2];
  logic [CW-1:0] hold_w  [2];
  logic          tp_w    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = fixed priority, 1 = round robin
  int m_owner [2];
  int m_cnt   [2];
  int m_ptr   [2];
  bit m_tp    [2];

  always #5 clk = ~clk;

  mutex_arbiter_n #(.N_REQ(4), .MODE(0), .MAX_HOLD(4)) u_prio (
    .bus_clk_i       (clk),
    .bus_rst_ni      (rst_n),
    .arb_en_i        (arb_en),
    .req_i           (req),
    .grant_o         (grant_w[0]),
    .grant_valid_o   (valid_w[0]),
    .grant_idx_o     (idx_w[0]),
    .hold_cnt_o      (hold_w[0]),
    .timeout_pulse_o (tp_w[0])
  );

  mutex_arbiter_n #(.N_REQ(4), .MODE(1), .MAX_HOLD(4)) u_rr (
    .bus_clk_i       (clk),
    .bus_rst_ni      (rst_n),
    .arb_en_i        (arb_en),
    .req_i           (req),
    .grant_o         (grant_w[1]),
    .grant_valid_o   (valid_w[1]),
    .grant_idx_o     (idx_w[1]),
    .hold_cnt_o      (hold_w[1]),
    .timeout_pulse_o (tp_w[1])
  );

  function automatic int model_pick(input int mode, input logic [N-1:0] r, input int ptr);
    int j;
    if (mode == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (((r >> i) & 4'd1) != 4'd0) return i;
      end
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant(input int m);
    logic [N-1:0] one;
    one = 4'd1;
    return (m_owner[m] < 0) ? 4'd0 : (one << m_owner[m]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    int o;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_owner[m] <= -1;
        m_cnt[m]   <= 0;
        m_ptr[m]   <= 0;
        m_tp[m]    <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        o = m_owner[m];
        if (o < 0) begin
          w = model_pick(m, req, m_ptr[m]);
          m_tp[m] <= 1'b0;
          if (arb_en && w >= 0) begin
            m_owner[m] <= w;
            m_cnt[m]   <= 1;
            m_ptr[m]   <= (w + 1) % N;
          end
        end else if (((req >> o) & 4'd1) == 4'd0) begin
          m_owner[m] <= -1;
          m_cnt[m]   <= 0;
          m_tp[m]    <= 1'b0;
        end else if (m_cnt[m] == MH && (req & ~(4'd1 << o)) != 4'd0) begin
          m_owner[m] <= -1;
          m_cnt[m]   <= 0;
          m_tp[m]    <= 1'b1;
        end else begin
          m_cnt[m] <= (m_cnt[m] >= MH) ? MH : m_cnt[m] + 1;
          m_tp[m]  <= 1'b0;
        end
      end
    end
  end

  task automatic settle();
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    arb_en = 1'b1;
    req    = 4'b1111;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (grant_w[m] !== 4'b0000 || valid_w[m] !== 1'b0 || hold_w[m] !== 3'd0 ||
          tp_w[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: grant=%b valid=%b hold=%0d tp=%b, required 0000 0 0 0",
                 m, grant_w[m], valid_w[m], hold_w[m], tp_w[m]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_w[1] !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release_rr: grant=%b, required 0001", grant_w[1]);
    end
    n_checks++;
    if (grant_w[0] !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release_prio: grant=%b, required 1000", grant_w[0]);
    end
  endtask

  task automatic test_fixed_priority();
    settle();
    req = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (grant_w[0] !== 4'b0100 || idx_w[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL prio_win: grant=%b idx=%0d, required 0100 2", grant_w[0], idx_w[0]);
    end
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant_w[0] !== 4'b0000 || valid_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_dead_cycle: grant=%b valid=%b, required 0000 0", grant_w[0], valid_w[0]);
    end
    @(negedge clk);
    n_checks++;
    if (grant_w[0] !== 4'b0001 || idx_w[0] !== 2'd0 || valid_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_next: grant=%b idx=%0d valid=%b, required 0001 0 1",
               grant_w[0], idx_w[0], valid_w[0]);
    end
    n_checks++;
    if (grant_w[1] !== exp_grant(1)) begin
      n_fail++;
      $display("FAIL prio_phase_rr_model: grant=%b, required %b", grant_w[1], exp_grant(1));
    end
  endtask

  task automatic test_rr_timeout();
    int           pulses;
    int           slot;
    int           phase;
    logic [N-1:0] eg;
    logic [N-1:0] one;
    logic [CW-1:0] eh;
    one    = 4'd1;
    pulses = 0;
    rst_n  = 1'b0;
    req    = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      slot  = c / 5;
      phase = c % 5;
      eg    = (phase < 4) ? (one << (slot % 4)) : 4'd0;
      eh    = (phase < 4) ? CW'(phase + 1) : 3'd0;
      if (c < 20 && tp_w[1] === 1'b1) pulses++;
      n_checks++;
      if (grant_w[1] !== eg || hold_w[1] !== eh || tp_w[1] !== (phase == 4)) begin
        n_fail++;
        $display("FAIL rr_rotation c=%0d: grant=%b hold=%0d tp=%b, required %b %0d %b",
                 c, grant_w[1], hold_w[1], tp_w[1], eg, eh, phase == 4);
      end
      n_checks++;
      if (grant_w[0] !== exp_grant(0) || tp_w[0] !== m_tp[0]) begin
        n_fail++;
        $display("FAIL rr_phase_prio_model c=%0d: grant=%b tp=%b, required %b %b",
                 c, grant_w[0], tp_w[0], exp_grant(0), m_tp[0]);
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL rr_pulse_count: pulses=%0d, required 4", pulses);
    end
  endtask

  task automatic test_saturation();
    int eh;
    settle();
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      eh = (c + 1 > MH) ? MH : c + 1;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (grant_w[m] !== 4'b0010 || hold_w[m] !== CW'(eh) || tp_w[m] !== 1'b0) begin
          n_fail++;
          $display("FAIL saturation[%0d] c=%0d: grant=%b hold=%0d tp=%b, required 0010 %0d 0",
                   m, c, grant_w[m], hold_w[m], tp_w[m], eh);
        end
      end
    end
  endtask

  task automatic test_enable();
    settle();
    arb_en = 1'b0;
    req    = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant_w[0] !== 4'b0000 || grant_w[1] !== 4'b0000) begin
        n_fail++;
        $display("FAIL enable_gated c=%0d: grant=%b/%b, required 0000/0000",
                 c, grant_w[0], grant_w[1]);
      end
    end
    arb_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_w[1] !== 4'b0010 || idx_w[1] !== 2'd1) begin
      n_fail++;
      $display("FAIL enable_issue: grant=%b idx=%0d, required 0010 1", grant_w[1], idx_w[1]);
    end
    arb_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant_w[1] !== 4'b0010) begin
        n_fail++;
        $display("FAIL enable_hold c=%0d: grant=%b, required 0010", c, grant_w[1]);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (grant_w[1] !== 4'b0000) begin
      n_fail++;
      $display("FAIL enable_release: grant=%b, required 0000", grant_w[1]);
    end
    arb_en = 1'b1;
  endtask

  task automatic test_async_reset();
    settle();
    req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (grant_w[1] !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_setup: grant=%b, required 0100", grant_w[1]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (grant_w[m] !== 4'b0000 || valid_w[m] !== 1'b0 || hold_w[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL async_clear[%0d]: grant=%b valid=%b hold=%0d, required 0000 0 0",
                 m, grant_w[m], valid_w[m], hold_w[m]);
      end
    end
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_w[1] !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_ptr_reset: grant=%b, required 0001", grant_w[1]);
    end
  endtask

  task automatic test_random();
    logic [1:0]    ei;
    logic [CW-1:0] eh;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      arb_en = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        ei = (m_owner[m] < 0) ? 2'd0 : m_owner[m][1:0];
        eh = CW'(m_cnt[m]);
        n_checks++;
        if (grant_w[m] !== exp_grant(m) || valid_w[m] !== (m_owner[m] >= 0) ||
            idx_w[m] !== ei || hold_w[m] !== eh || tp_w[m] !== m_tp[m]) begin
          n_fail++;
          $display("FAIL random[%0d] c=%0d: g=%b v=%b i=%0d h=%0d t=%b, required %b %b %0d %0d %b",
                   m, c, grant_w[m], valid_w[m], idx_w[m], hold_w[m], tp_w[m],
                   exp_grant(m), m_owner[m] >= 0, ei, eh, m_tp[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rr_timeout();
    test_saturation();
    test_enable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
